// File: rtl/usb_frame_pkg.sv
// Shared constants and state encoding for the FT245 frame transmitter.
package usb_frame_pkg;

  localparam logic [7:0] StartFlagDefault = 8'h5A;
  localparam logic [7:0] StopFlagDefault  = 8'hA5;

  typedef enum logic [5:0] {
    StIdle    = 6'b000001,
    StStart   = 6'b000010,
    StSeq     = 6'b000100,
    StPayload = 6'b001000,
    StStop    = 6'b010000,
    StDone    = 6'b100000
  } state_e;

endpackage

// File: rtl/usb_tx_skid.sv
// Two-entry skid buffer between the FIFO read port and the FT output register.
module usb_tx_skid #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]            count_q, count_d;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) mem0_d = push_data;
        else                 mem1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous pop and push keeps occupancy; new data goes behind any remaining entry.
        if (count_q == 2'd1) begin
          mem0_d = push_data;
        end else begin
          mem0_d = mem1_q;
          mem1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head  = mem0_q;
  assign count = count_q;

endmodule

// File: rtl/usb_frame_tx.sv
// Sequences START, payload drained from the sample FIFO, and STOP onto the FT245 write port.
// Define USB_FRAME_SEQ_EN to insert an 8-bit frame sequence byte after START.
module usb_frame_tx
  import usb_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FRAME_BYTES = 40960,
  parameter logic [DATA_WIDTH-1:0] START_FLAG = DATA_WIDTH'(StartFlagDefault),
  parameter logic [DATA_WIDTH-1:0] STOP_FLAG  = DATA_WIDTH'(StopFlagDefault)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_rdy_i,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  underrun_o,
  output logic                  fifo_ren_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  input  logic                  fifo_empty_i,
  input  logic                  ft_txe_n_i,
  output logic                  ft_wr_n_o,
  output logic [DATA_WIDTH-1:0] ft_data_o
);

  localparam int unsigned CntW = $clog2(FRAME_BYTES + 1);
  localparam logic [CntW-1:0] FrameCnt = CntW'(FRAME_BYTES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  state_e                state_q, state_d;
  logic                  wr_n_q, wr_n_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]       rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d;
  logic                  ren_q, ren;
  logic                  underrun_q, underrun_d;
`ifdef USB_FRAME_SEQ_EN
  logic [7:0]            seq_q, seq_d;
`endif

  logic                  accept, load, take, avail, reading;
  logic                  skid_push, skid_pop;
  logic [DATA_WIDTH-1:0] skid_head, next_byte;
  logic [1:0]            skid_count;
  logic [2:0]            occ_next;

  usb_tx_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (skid_push),
    .push_data(fifo_rdata_i),
    .pop      (skid_pop),
    .head     (skid_head),
    .count    (skid_count)
  );

  assign accept    = !wr_n_q && !ft_txe_n_i;
  // Oldest byte is either in the skid buffer or arriving this cycle from the FIFO.
  assign avail     = (skid_count != 2'd0) || ren_q;
  assign next_byte = (skid_count != 2'd0) ? skid_head : fifo_rdata_i;
  assign reading   = (state_q == StStart) || (state_q == StSeq) || (state_q == StPayload);

  always_comb begin
    state_d    = state_q;
    wr_n_d     = wr_n_q;
    data_d     = data_q;
    tx_cnt_d   = tx_cnt_q;
    underrun_d = underrun_q;
    load       = 1'b0;
    take       = 1'b0;
`ifdef USB_FRAME_SEQ_EN
    seq_d      = seq_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (frame_rdy_i) begin
          state_d    = StStart;
          wr_n_d     = 1'b0;
          data_d     = START_FLAG;
          underrun_d = 1'b0;
        end
      end
      StStart: begin
        if (accept) begin
`ifdef USB_FRAME_SEQ_EN
          state_d = StSeq;
          data_d  = DATA_WIDTH'(seq_q);
`else
          state_d = StPayload;
          load    = 1'b1;
`endif
        end
      end
      StSeq: begin
        if (accept) begin
          state_d = StPayload;
          load    = 1'b1;
        end
      end
      StPayload: begin
        if (accept) begin
          tx_cnt_d = tx_cnt_q + CntOne;
          if (tx_cnt_q + CntOne == FrameCnt) begin
            state_d = StStop;
            data_d  = STOP_FLAG;
          end else begin
            load = 1'b1;
          end
        end else if (wr_n_q) begin
          load = 1'b1;
        end
      end
      StStop: begin
        if (accept) begin
          state_d = StDone;
          wr_n_d  = 1'b1;
`ifdef USB_FRAME_SEQ_EN
          seq_d   = seq_q + 8'd1;
`endif
        end
      end
      StDone: begin
        if (!frame_rdy_i) begin
          state_d  = StIdle;
          tx_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (avail) begin
        take   = 1'b1;
        data_d = next_byte;
        wr_n_d = 1'b0;
      end else begin
        wr_n_d = 1'b1;
      end
    end

    if (reading && fifo_empty_i && (rd_cnt_q < FrameCnt)) underrun_d = 1'b1;
  end

  // Arriving data bypasses the skid buffer when it is empty and the output is being refilled.
  assign skid_push = ren_q && !(take && (skid_count == 2'd0));
  assign skid_pop  = take && (skid_count != 2'd0);
  assign occ_next  = 3'(skid_count) + 3'(ren_q) - 3'(take);
  assign ren       = reading && (rd_cnt_q < FrameCnt) && !fifo_empty_i && (occ_next < 3'd2);

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (state_q == StDone && !frame_rdy_i) rd_cnt_d = '0;
    else if (ren)                          rd_cnt_d = rd_cnt_q + CntOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_n_q     <= 1'b1;
      data_q     <= '0;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      ren_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_n_q     <= wr_n_d;
      data_q     <= data_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      ren_q      <= ren;
      underrun_q <= underrun_d;
    end
  end

`ifdef USB_FRAME_SEQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_q <= 8'd0;
    else        seq_q <= seq_d;
  end
`endif

  assign ft_wr_n_o    = wr_n_q;
  assign ft_data_o    = data_q;
  assign fifo_ren_o   = ren;
  assign frame_done_o = (state_q == StDone);
  assign busy_o       = (state_q != StIdle);
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_usb_frame_tx.sv
// Directed bench for usb_frame_tx with a 4-byte frame and a behavioural sample FIFO.
module tb_usb_frame_tx;

  localparam int unsigned Fb = 4;
`ifdef USB_FRAME_SEQ_EN
  localparam int FrameLen = 7;
`else
  localparam int FrameLen = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_rdy_i;
  logic       frame_done_o, busy_o, underrun_o, fifo_ren_o;
  logic [7:0] fifo_rdata_i;
  logic       fifo_empty_i;
  logic       ft_txe_n_i;
  logic       ft_wr_n_o;
  logic [7:0] ft_data_o;

  always #5 clk = ~clk;

  usb_frame_tx #(
    .DATA_WIDTH (8),
    .FRAME_BYTES(Fb)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_rdy_i (frame_rdy_i),
    .frame_done_o(frame_done_o),
    .busy_o      (busy_o),
    .underrun_o  (underrun_o),
    .fifo_ren_o  (fifo_ren_o),
    .fifo_rdata_i(fifo_rdata_i),
    .fifo_empty_i(fifo_empty_i),
    .ft_txe_n_i  (ft_txe_n_i),
    .ft_wr_n_o   (ft_wr_n_o),
    .ft_data_o   (ft_data_o)
  );

  // Sample FIFO model: write side owned by the stimulus, read side by this block.
  logic [7:0] fifo_mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign fifo_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_ren_o && (rd_ptr != wr_ptr)) begin
      fifo_rdata_i <= fifo_mem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Wire monitor: accepted bytes, read pulses, hold violations under back-pressure.
  logic [7:0] acc_q[$];
  int         acc_cyc[$];
  int         cyc = 0;
  int         ren_cnt = 0;
  int         ren_bad = 0;
  int         hold_err = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (hold_pend && (ft_wr_n_o || ft_data_o != hold_data)) hold_err++;
      hold_pend = !ft_wr_n_o && ft_txe_n_i;
      hold_data = ft_data_o;
      if (!ft_wr_n_o && !ft_txe_n_i) begin
        acc_q.push_back(ft_data_o);
        acc_cyc.push_back(cyc);
      end
      if (fifo_ren_o) ren_cnt++;
      if (fifo_ren_o && fifo_empty_i) ren_bad++;
    end else begin
      hold_pend = 1'b0;
    end
  end

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_seq = 8'h00;
  int         base;
  int         ren_base;
  int         n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic load_fifo(input logic [31:0] pay, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      fifo_mem[wr_ptr % 64] = pay[31-8*i -: 8];
      wr_ptr++;
    end
  endtask

  task automatic wait_done(input string tag, input bit alt, input int budget);
    for (int i = 0; i < budget && !frame_done_o; i++) begin
      @(negedge clk);
      if (alt) ft_txe_n_i = ~ft_txe_n_i;
    end
    ft_txe_n_i = 1'b0;
    check({tag, "_done"}, 32'(frame_done_o), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] pay, input int b);
    logic [7:0] exp_q[$];
    int         got_n;
    exp_q.push_back(8'h5A);
`ifdef USB_FRAME_SEQ_EN
    exp_q.push_back(exp_seq);
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back(pay[31-8*i -: 8]);
    exp_q.push_back(8'hA5);
    got_n = acc_q.size() - b;
    check({tag, "_len"}, 32'(got_n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b + i < acc_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(acc_q[b+i]), 32'(exp_q[i]));
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] pay);
    load_fifo(pay, 4);
    base = acc_q.size();
    frame_rdy_i = 1'b1;
    wait_done(tag, 1'b0, 60);
    check_frame(tag, pay, base);
    frame_rdy_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_rdy_i = 1'b0;
    ft_txe_n_i  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_n", 32'(ft_wr_n_o), 32'd1);
    check("rst_data", 32'(ft_data_o), 32'd0);
    check("rst_ren", 32'(fifo_ren_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_underrun", 32'(underrun_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: clean frame at full rate.
    load_fifo(32'h11223344, 4);
    base = acc_q.size();
    ren_base = ren_cnt;
    frame_rdy_i = 1'b1;
    wait_done("t1", 1'b0, 60);
    n = acc_cyc.size();
    check("t1_done_lat", 32'(acc_cyc[n-1]), 32'(cyc));
    check("t1_b2b", 32'(acc_cyc[n-1] - acc_cyc[n-5]), 32'd4);
    check("t1_ren_cnt", 32'(ren_cnt - ren_base), 32'd4);
    check_frame("t1", 32'h11223344, base);

    // Test 4: level still high in DONE must not restart.
    repeat (5) @(negedge clk);
    check("t4_no_restart", 32'(acc_q.size() - base), 32'(FrameLen));
    check("t4_done_held", 32'(frame_done_o), 32'd1);
    frame_rdy_i = 1'b0;
    @(negedge clk);
    check("t4_done_fall", 32'(frame_done_o), 32'd0);
    check("t4_idle", 32'(busy_o), 32'd0);

    // Test 2: back-pressure toggling every cycle.
    load_fifo(32'h11223344, 4);
    base = acc_q.size();
    frame_rdy_i = 1'b1;
    @(negedge clk);
    check("t4_restart_wr", 32'(ft_wr_n_o), 32'd0);
    check("t4_restart_data", 32'(ft_data_o), 32'h5A);
    wait_done("t2", 1'b1, 80);
    check_frame("t2", 32'h11223344, base);
    check("t2_hold", 32'(hold_err), 32'd0);
    frame_rdy_i = 1'b0;
    @(negedge clk);

    // Test 3: FIFO runs dry after two payload bytes.
    load_fifo(32'hC1C20000, 2);
    base = acc_q.size();
    frame_rdy_i = 1'b1;
    for (int i = 0; i < 40 && (acc_q.size() - base) < FrameLen - 3; i++) @(negedge clk);
    check("t3_reach_gap", 32'(acc_q.size() - base), 32'(FrameLen - 3));
    check("t3_underrun", 32'(underrun_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t3_gap%0d", i), 32'(ft_wr_n_o), 32'd1);
    end
    load_fifo(32'hC3C40000, 2);
    wait_done("t3", 1'b0, 60);
    check_frame("t3", 32'hC1C2C3C4, base);
    check("t3_underrun_sticky", 32'(underrun_o), 32'd1);
    frame_rdy_i = 1'b0;
    @(negedge clk);
    load_fifo(32'h55667788, 4);
    base = acc_q.size();
    frame_rdy_i = 1'b1;
    @(negedge clk);
    check("t3_underrun_clr", 32'(underrun_o), 32'd0);
    wait_done("t3b", 1'b0, 60);
    check_frame("t3b", 32'h55667788, base);
    frame_rdy_i = 1'b0;
    @(negedge clk);

    // Test 5: reset in the middle of the payload.
    load_fifo(32'h99AABBCC, 4);
    base = acc_q.size();
    frame_rdy_i = 1'b1;
    for (int i = 0; i < 40 && (acc_q.size() - base) < FrameLen - 3; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_wr_n", 32'(ft_wr_n_o), 32'd1);
    check("t5_ren", 32'(fifo_ren_o), 32'd0);
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_data", 32'(ft_data_o), 32'd0);
    wr_ptr = rd_ptr;
    exp_seq = 8'h00;
    frame_rdy_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("t5", 32'h0102A5A5);

`ifdef USB_FRAME_SEQ_EN
    // Test 6: sequence byte increments per frame and wraps.
    for (int f = 0; f < 254; f++) run_frame($sformatf("t6_f%0d", f), 32'(f));
    check("t6_seq_ff", 32'(exp_seq), 32'hFF);
    run_frame("t6_ff", 32'hDEADBEEF);
    run_frame("t6_wrap", 32'hCAFEF00D);
`endif

    check("ren_never_empty", 32'(ren_bad), 32'd0);
    check("hold_all", 32'(hold_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_frame_tx.md
Name: usb_frame_tx

Overview:
Transmit scheduler in the FT2232H clock domain (60 MHz ft_clkout). Once the producer hands over a filled sample FIFO, it sequences one frame onto the FT245 synchronous write port: START flag, exactly FRAME_BYTES payload bytes drained from the FIFO, then STOP flag. It then signals completion back to the producer. It absorbs the FIFO's 1-cycle read latency and arbitrary ft_txe_n back-pressure without losing or duplicating bytes.

Parameters:
DATA_WIDTH, 8, USB byte width.
FRAME_BYTES, 40960, payload bytes per frame (20480 raw samples x 2 bytes).
START_FLAG, 8'h5A, frame header byte.
STOP_FLAG, 8'hA5, frame trailer byte.

Ports:
clk  in  1  FT2232H clkout, 60 MHz; sole clock.
rst_n  in  1  asynchronous, active-low reset.
frame_rdy_i  in  1  level, already synchronized; producer has filled the FIFO.
frame_done_o  out  1  level; frame fully sent; held until frame_rdy_i falls.
busy_o  out  1  high in any state other than IDLE.
underrun_o  out  1  sticky; FIFO went empty mid-payload; cleared on next frame start.
fifo_ren_o  out  1  FIFO read enable; rdata is valid on the cycle after ren.
fifo_rdata_i  in  DATA_WIDTH  FIFO read data.
fifo_empty_i  in  1  FIFO empty.
ft_txe_n_i  in  1  low = FT FIFO can accept a byte.
ft_wr_n_o  out  1  registered write strobe, active low.
ft_data_o  out  DATA_WIDTH  registered write data.

Behaviour:
- Reset values: ft_wr_n_o=1, ft_data_o=0, fifo_ren_o=0, frame_done_o=0, busy_o=0, underrun_o=0; state IDLE; counters 0; skid buffer empty.
- Byte acceptance: a byte is accepted at a rising edge where ft_wr_n_o==0 and ft_txe_n_i==0. Until accepted, ft_data_o and ft_wr_n_o hold their values. No byte is ever presented twice after acceptance.
- States:
  - IDLE: when frame_rdy_i is sampled high at edge k, go to START. START_FLAG is presented with ft_wr_n_o=0 in cycle k+1. underrun_o clears.
  - START: on acceptance, go to PAYLOAD (or SEQ if the optional feature is enabled).
  - PAYLOAD:
    - rd_cnt counts FIFO reads issued; tx_cnt counts payload bytes accepted. Both are $clog2(FRAME_BYTES+1) bits wide.
    - fifo_ren_o = (rd_cnt < FRAME_BYTES) && !fifo_empty_i && (skid occupancy + reads in flight < 2).
    - Read data lands in a 2-entry skid buffer. The head of the buffer drives ft_data_o with ft_wr_n_o=0. When the buffer is empty, ft_wr_n_o=1.
    - Sustained throughput: 1 byte/cycle while ft_txe_n_i is low and the FIFO is non-empty.
    - When tx_cnt reaches FRAME_BYTES, go to STOP. No extra FIFO read is ever issued.
  - STOP: present STOP_FLAG; on acceptance, go to DONE.
  - DONE: frame_done_o=1, ft_wr_n_o=1. When frame_rdy_i is sampled low, go to IDLE and frame_done_o falls on the same edge.
- Underrun: fifo_empty_i high while rd_cnt < FRAME_BYTES sets underrun_o. The block stalls (no reads, and ft_wr_n_o=1 once the skid buffer drains) and resumes when data returns. The frame is never truncated.
- frame_rdy_i dropping mid-frame is ignored; the frame completes. frame_rdy_i still high in DONE does not start a new frame; a fresh rising level is required.
- ft_txe_n_i toggling every cycle: same byte order and count, with the rate limited by ft_txe_n_i.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). The partial frame is abandoned, and FIFO flushing is the caller's responsibility.
- fifo_ren_o is never asserted when fifo_empty_i is high (no read from an empty FIFO).

Optional Feature:
USB_FRAME_SEQ_EN:
- Defined: adds state SEQ between START and PAYLOAD, which presents an 8-bit frame sequence number. The counter resets to 0, increments on each STOP acceptance, and wraps 255->0. Frame length on the wire is FRAME_BYTES+3.
- Undefined: no SEQ state and no counter. Frame length on the wire is FRAME_BYTES+2.

Decomposition:
- Package usb_frame_pkg: START_FLAG/STOP_FLAG defaults and the state encoding (IDLE, START, SEQ, PAYLOAD, STOP, DONE), one-hot 6 bits.
- Sub-module usb_tx_skid: 2-entry skid buffer with push (registered rdata valid), pop (acceptance), head data, count. Tested standalone.

Test Plan:
1. FRAME_BYTES=4, FIFO preloaded 11,22,33,44, txe_n=0, frame_rdy_i pulse held high -> 6 consecutive accepted bytes 5A,11,22,33,44,A5. frame_done_o rises the cycle after the A5 acceptance. Exactly 4 fifo_ren_o pulses.
2. Same as 1 with ft_txe_n_i alternating 1/0 each cycle -> identical byte sequence, no duplicates, with ft_data_o stable while ft_txe_n_i is high.
3. FRAME_BYTES=4, fifo_empty_i forced high for 5 cycles after the 2nd payload byte -> underrun_o=1, ft_wr_n_o=1 during the gap, then 33,44,A5 sent. underrun_o clears on the next frame.
4. frame_rdy_i held high after done -> no second 5A. Drop frame_rdy_i -> IDLE and frame_done_o=0. Raise it again -> new frame starts.
5. rst_n low during the 3rd payload byte -> ft_wr_n_o=1, fifo_ren_o=0, busy_o=0 immediately. After release, the next frame starts cleanly with 5A.
6. USB_FRAME_SEQ_EN defined, 3 frames -> 2nd byte of each frame is 00, 01, 02. Forcing the counter to 255 -> next frame 0xFF, the following 0x00.
